// File: rtl/alu_core_if.sv
// rtl/alu_core_if.sv - operand/result bus between the EX-stage muxes and the RV64 execute unit
//
// Purpose : groups the operand, decode and result signals of alu_core into one bundle.
// Ports   : master drives A, B, Cin, ALUOp, Func3 and Func7 and observes the results.
//           slave (alu_core) returns ALUCtrl, Result, Zero, Cout, Overflow and OvfSticky.
interface alu_core_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            Cin;
  logic [6:0]      ALUOp;
  logic [2:0]      Func3;
  logic [6:0]      Func7;
  logic [3:0]      ALUCtrl;
  logic [XLEN-1:0] Result;
  logic            Zero;
  logic            Cout;
  logic            Overflow;
  logic            OvfSticky;

  modport master (
    output A, B, Cin, ALUOp, Func3, Func7,
    input  ALUCtrl, Result, Zero, Cout, Overflow, OvfSticky
  );

  modport slave (
    input  A, B, Cin, ALUOp, Func3, Func7,
    output ALUCtrl, Result, Zero, Cout, Overflow, OvfSticky
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - RV64 integer execute unit: opcode/funct decode plus combinational 64-bit ALU
//
// Purpose : decodes ALUOp/Func3/Func7 into ALUCtrl and computes Result, Zero, Cout and Overflow
//           combinationally; OvfSticky is the only state and records any Overflow since reset.
// Ports   : Clk   - clock, OvfSticky updates on its rising edge
//           Rst_n - asynchronous active-low reset, clears OvfSticky
//           bus   - alu_core_if.slave: operands/decode fields in, results out
// Option  : ALU_MULDIV_EN - when defined, MUL/DIV/REM are built; otherwise Func7 = 0000001
//           decodes to a reserved code and no multiplier/divider exists.
module alu_core #(
  parameter int XLEN = 64
) (
  input  logic     Clk,
  input  logic     Rst_n,
  alu_core_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_MUL   = 4'd10,
    OP_DIV   = 4'd11,
    OP_REM   = 4'd12,
    OP_RSVD  = 4'd13,
    OP_PASSB = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [XLEN-1:0] a, b, result;
  logic [XLEN:0]   sum_ext, dif_ext;
  logic [SHW-1:0]  shamt;
  logic            cout, ovf, ovf_sticky_q;
  alu_op_e         ctrl;

  assign a     = bus.A;
  assign b     = bus.B;
  assign shamt = b[SHW-1:0];

  // Func3 mapping shared by R-type (Func7 = 0) and I-type ALU instructions.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    ctrl = OP_ADD;
    case (bus.ALUOp)
      OPC_RTYPE: begin
        case (bus.Func7)
          7'b0000000: ctrl = base_op(bus.Func3);
          7'b0100000: begin
            case (bus.Func3)
              3'b000:  ctrl = OP_SUB;
              3'b101:  ctrl = OP_SRA;
              default: ctrl = OP_RSVD;
            endcase
          end
`ifdef ALU_MULDIV_EN
          7'b0000001: begin
            case (bus.Func3)
              3'b000:  ctrl = OP_MUL;
              3'b100:  ctrl = OP_DIV;
              3'b110:  ctrl = OP_REM;
              default: ctrl = OP_RSVD;
            endcase
          end
`endif
          default: ctrl = OP_RSVD;
        endcase
      end
      // Immediate forms have no SUB; only the shift-right uses Func7[5] to pick SRAI.
      OPC_ITYPE: begin
        if (bus.Func3 == 3'b101 && bus.Func7[5]) ctrl = OP_SRA;
        else                                      ctrl = base_op(bus.Func3);
      end
      OPC_LOAD, OPC_STORE: ctrl = OP_ADD;
      OPC_BRANCH:          ctrl = OP_SUB;
      OPC_LUI:             ctrl = OP_PASSB;
      default:             ctrl = OP_ADD;
    endcase
  end

  // 65-bit forms give the carry (ADD) and the inverted borrow (SUB) directly.
  assign sum_ext = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, bus.Cin};
  assign dif_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
    case (ctrl)
      OP_ADD: begin
        result = sum_ext[XLEN-1:0];
        cout   = sum_ext[XLEN];
        ovf    = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        result = dif_ext[XLEN-1:0];
        cout   = ~dif_ext[XLEN];
        ovf    = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      OP_SLL:   result = a << shamt;
      OP_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:   result = a ^ b;
      OP_SRL:   result = a >> shamt;
      OP_SRA:   result = $signed(a) >>> shamt;
      OP_OR:    result = a | b;
      OP_AND:   result = a & b;
      OP_PASSB: result = b;
`ifdef ALU_MULDIV_EN
      // Low half of the product is identical for signed and unsigned operands.
      OP_MUL:   result = a * b;
      // Divide-by-zero and MIN/-1 are resolved before the divider output is used.
      OP_DIV: begin
        if (b == '0)
          result = '1;
        else if (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1)
          result = a;
        else
          result = $signed(a) / $signed(b);
      end
      OP_REM: begin
        if (b == '0)
          result = a;
        else if (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1)
          result = '0;
        else
          result = $signed(a) % $signed(b);
      end
`endif
      default:  result = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)   ovf_sticky_q <= 1'b0;
    else if (ovf) ovf_sticky_q <= 1'b1;
  end

  assign bus.ALUCtrl   = ctrl;
  assign bus.Result    = result;
  assign bus.Zero      = (result == '0);
  assign bus.Cout      = cout;
  assign bus.Overflow  = ovf;
  assign bus.OvfSticky = ovf_sticky_q;
endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - vector-table and scoreboard bench for alu_core
module tb_alu_core;
  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] FS = 7'b0100000;
  localparam logic [6:0] FM = 7'b0000001;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [3:0]  ctrl;
    logic        rsv;
    logic [63:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  alu_core_if #(.XLEN(64)) bus ();

  alu_core #(.XLEN(64)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [63:0] a, input logic [63:0] b,
                     input logic cin, input logic [3:0] ctrl, input logic rsv,
                     input logic [63:0] res, input logic cout, input logic ovf);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.cin = cin;
    v.ctrl = ctrl; v.rsv = rsv; v.res = res; v.cout = cout; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] a, input logic [63:0] b, input logic cin);
    bus.ALUOp = op; bus.Func3 = f3; bus.Func7 = f7;
    bus.A = a; bus.B = b; bus.Cin = cin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    //   name        op  f3      f7  A             B                 cin ctrl rsv res                        cout ovf
    add("add_20_22", R,  3'd0,   F0, 64'd20,       64'd22,           0,  0,   0, 64'd42,                    0,   0);
    add("add_cin",   R,  3'd0,   F0, 64'd10,       64'd10,           1,  0,   0, 64'd21,                    0,   0);
    add("add_111",   R,  3'd0,   F0, 64'd1,        64'd1,            1,  0,   0, 64'd3,                     0,   0);
    add("add_ovf",   R,  3'd0,   F0, MAXP,         64'd1,            0,  0,   0, MINN,                      0,   1);
    add("add_wrap",  R,  3'd0,   F0, ONES,         64'd1,            0,  0,   0, 64'd0,                     1,   0);
    add("sub_50_20", R,  3'd0,   FS, 64'd50,       64'd20,           1,  1,   0, 64'd30,                    1,   0);
    add("sub_0_1",   R,  3'd0,   FS, 64'd0,        64'd1,            1,  1,   0, ONES,                      0,   0);
    add("sub_ovf",   R,  3'd0,   FS, MINN,         64'd1,            0,  1,   0, MAXP,                      1,   1);
    add("slt_5_10",  R,  3'd2,   F0, 64'd5,        64'd10,           0,  3,   0, 64'd1,                     0,   0);
    add("slt_neg",   R,  3'd2,   F0, ONES,         64'd1,            0,  3,   0, 64'd1,                     0,   0);
    add("sltu_neg",  R,  3'd3,   F0, ONES,         64'd1,            0,  4,   0, 64'd0,                     0,   0);
    add("and_12_5",  R,  3'd7,   F0, 64'd12,       64'd5,            0,  9,   0, 64'd4,                     0,   0);
    add("xor_5_5",   R,  3'd4,   F0, 64'd5,        64'd5,            0,  5,   0, 64'd0,                     0,   0);
    add("or_12_5",   R,  3'd6,   F0, 64'd12,       64'd5,            0,  8,   0, 64'd13,                    0,   0);
    add("sll_63",    R,  3'd1,   F0, 64'd1,        64'h7F,           0,  2,   0, MINN,                      0,   0);
    add("srl_4",     R,  3'd5,   F0, MINN,         64'd4,            0,  6,   0, 64'h0800_0000_0000_0000,   0,   0);
    add("sra_4",     R,  3'd5,   FS, MINN,         64'd4,            0,  7,   0, 64'hF800_0000_0000_0000,   0,   0);
    add("srai_4",    I,  3'd5,   FS, MINN,         64'd4,            0,  7,   0, 64'hF800_0000_0000_0000,   0,   0);
    add("srli_4",    I,  3'd5,   F0, MINN,         64'd4,            0,  6,   0, 64'h0800_0000_0000_0000,   0,   0);
    add("addi_f7",   I,  3'd0,   FS, 64'd50,       64'd20,           0,  0,   0, 64'd70,                    0,   0);
    add("lui",       LU, 3'd0,   F0, 64'd7,        64'h1234_5000,    0,  15,  0, 64'h1234_5000,             0,   0);
    add("load",      LD, 3'd3,   F0, 64'd100,      64'd8,            0,  0,   0, 64'd108,                   0,   0);
    add("branch",    BR, 3'd0,   F0, 64'd5,        64'd5,            0,  1,   0, 64'd0,                     1,   0);
    add("rsv_sub",   R,  3'd1,   FS, 64'd5,        64'd5,            0,  0,   1, 64'd0,                     0,   0);
    add("rsv_f7",    R,  3'd0,   7'h7F, 64'd5,     64'd5,            1,  0,   1, 64'd0,                     0,   0);
    add("opc_other", 7'h7F, 3'd0, F0, 64'd2,       64'd3,            0,  0,   0, 64'd5,                     0,   0);
`ifdef ALU_MULDIV_EN
    add("mul_3_4",   R,  3'd0,   FM, 64'd3,        64'd4,            0,  10,  0, 64'd12,                    0,   0);
    add("mul_neg",   R,  3'd0,   FM, -64'sd3,      64'd4,            0,  10,  0, -64'sd12,                  0,   0);
    add("div_40_5",  R,  3'd4,   FM, 64'd40,       64'd5,            0,  11,  0, 64'd8,                     0,   0);
    add("div_by0",   R,  3'd4,   FM, 64'd7,        64'd0,            0,  11,  0, ONES,                      0,   0);
    add("div_minm1", R,  3'd4,   FM, MINN,         ONES,             0,  11,  0, MINN,                      0,   0);
    add("rem_m7_2",  R,  3'd6,   FM, -64'sd7,      64'd2,            0,  12,  0, ONES,                      0,   0);
    add("rem_by0",   R,  3'd6,   FM, 64'd7,        64'd0,            0,  12,  0, 64'd7,                     0,   0);
    add("rem_minm1", R,  3'd6,   FM, MINN,         ONES,             0,  12,  0, 64'd0,                     0,   0);
`else
    add("mul_off",   R,  3'd0,   FM, 64'd3,        64'd4,            0,  0,   1, 64'd0,                     0,   0);
    add("div_off",   R,  3'd4,   FM, 64'd40,       64'd5,            0,  0,   1, 64'd0,                     0,   0);
    add("rem_off",   R,  3'd6,   FM, -64'sd7,      64'd2,            0,  0,   1, 64'd0,                     0,   0);
`endif

    // Reset holds the sticky flag low even with Overflow asserted across edges.
    Rst_n = 1'b0;
    drive(R, 3'd0, F0, MAXP, 64'd1, 1'b0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_sticky", {63'd0, bus.OvfSticky}, 64'd0);
    chk("rst_comb_ovf", {63'd0, bus.Overflow}, 64'd1);
    drive(R, 3'd0, F0, 64'd1, 64'd1, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1 chk("sticky_idle", {63'd0, bus.OvfSticky}, 64'd0);

    // Sticky sets only on the edge after Overflow, and clears asynchronously.
    drive(R, 3'd0, F0, MAXP, 64'd1, 1'b0);
    @(negedge Clk);
    chk("ovf_pre_edge", {63'd0, bus.Overflow}, 64'd1);
    chk("sticky_pre_edge", {63'd0, bus.OvfSticky}, 64'd0);
    @(posedge Clk);
    #1 chk("sticky_set", {63'd0, bus.OvfSticky}, 64'd1);
    drive(R, 3'd0, F0, 64'd1, 64'd1, 1'b0);
    @(posedge Clk);
    #1 chk("sticky_hold", {63'd0, bus.OvfSticky}, 64'd1);
    #2 Rst_n = 1'b0;
    #1 chk("sticky_async_clr", {63'd0, bus.OvfSticky}, 64'd0);
    chk("result_in_reset", bus.Result, 64'd2);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Vector table through the scoreboard.
    foreach (vecs[i]) begin
      @(posedge Clk);
      #1;
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].cin);
      exp_q.push_back(vecs[i]);
      @(negedge Clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = exp_q.pop_front();
        if (e.rsv) begin
          checks++;
          if (!(bus.ALUCtrl inside {4'd13, 4'd14})) begin
            errors++;
            $display("FAIL %s.ctrl: got %0d expected 13 or 14", e.name, bus.ALUCtrl);
          end
        end else begin
          chk({e.name, ".ctrl"}, {60'd0, bus.ALUCtrl}, {60'd0, e.ctrl});
        end
        chk({e.name, ".res"},  bus.Result, e.res);
        chk({e.name, ".zero"}, {63'd0, bus.Zero}, {63'd0, (e.res == 64'd0)});
        chk({e.name, ".cout"}, {63'd0, bus.Cout}, {63'd0, e.cout});
        chk({e.name, ".ovf"},  {63'd0, bus.Overflow}, {63'd0, e.ovf});
      end
    end
    @(posedge Clk);
    #1 chk("sticky_after_table", {63'd0, bus.OvfSticky}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
